// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared class codes, field widths and buffer entry type
// Contents: imm_cls_e (CLS_NONE..CLS_IMM11), field widths IMM*_W,
// buffer DEPTH, imm_entry_t = {cls, imm3, imm5, imm8, imm11} (30 bits).
package imm_pkg;

    localparam int DEPTH   = 2;
    localparam int IMM3_W  = 3;
    localparam int IMM5_W  = 5;
    localparam int IMM8_W  = 8;
    localparam int IMM11_W = 11;

    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_IMM3  = 3'd1,
        CLS_IMM5  = 3'd2,
        CLS_IMM8  = 3'd3,
        CLS_IMM11 = 3'd4
    } imm_cls_e;

    typedef struct packed {
        imm_cls_e             cls;
        logic [IMM3_W-1:0]    imm3;
        logic [IMM5_W-1:0]    imm5;
        logic [IMM8_W-1:0]    imm8;
        logic [IMM11_W-1:0]   imm11;
    } imm_entry_t;

endpackage

// File: rtl/imm_class_decode.sv
// rtl/imm_class_decode.sv - combinational instruction to immediate-field decode
// Ports: i_instr (16-bit instruction word), o_entry (class plus raw fields;
// fields not belonging to the class are zero).
module imm_class_decode
    import imm_pkg::*;
(
    input  logic [15:0] i_instr,
    output imm_entry_t  o_entry
);

    always_comb begin
        o_entry = '0;
        if (i_instr[15:10] == 6'b000111) begin
            o_entry.cls  = CLS_IMM3;
            o_entry.imm3 = i_instr[8:6];
        end else if ((i_instr[15:13] == 3'b000 && i_instr[12:11] != 2'b11) ||
                     (i_instr[15:13] == 3'b011) ||
                     (i_instr[15:12] == 4'b1000)) begin
            o_entry.cls  = CLS_IMM5;
            o_entry.imm5 = i_instr[10:6];
        end else if ((i_instr[15:13] == 3'b001) ||
                     (i_instr[15:11] == 5'b01001) ||
                     (i_instr[15:12] == 4'b1001) ||
                     (i_instr[15:12] == 4'b1010) ||
                     (i_instr[15:12] == 4'b1101 && i_instr[11:9] != 3'b111)) begin
            o_entry.cls  = CLS_IMM8;
            o_entry.imm8 = i_instr[7:0];
        end else if (i_instr[15:11] == 5'b11100) begin
            o_entry.cls   = CLS_IMM11;
            o_entry.imm11 = i_instr[10:0];
        end
    end

endmodule

// File: rtl/imm_field_extract.sv
// rtl/imm_field_extract.sv - immediate-field extractor with 2-entry output buffer
// Ports: CLK/RST (sync active-high), INSTR_VALID/INSTR_READY/INSTR input
// handshake, IMM_VALID/IMM_READY output handshake, IMM_CLASS and raw
// IMM3/IMM5/IMM8/IMM11 fields of the head entry, NONE_CNT saturating count
// of accepted unclassified instructions.
module imm_field_extract
    import imm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               INSTR_VALID,
    output logic               INSTR_READY,
    input  logic [15:0]        INSTR,
    output logic               IMM_VALID,
    input  logic               IMM_READY,
    output logic [2:0]         IMM_CLASS,
    output logic [IMM3_W-1:0]  IMM3,
    output logic [IMM5_W-1:0]  IMM5,
    output logic [IMM8_W-1:0]  IMM8,
    output logic [IMM11_W-1:0] IMM11,
    output logic [CNT_W-1:0]   NONE_CNT
);

    imm_entry_t        w_dec;
    imm_entry_t        w_head;
    logic              w_push;
    logic              w_pop;

    imm_entry_t        r_mem [DEPTH];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_count;
    logic [CNT_W-1:0]  r_none_cnt;

    imm_class_decode u_decode (
        .i_instr (INSTR),
        .o_entry (w_dec)
    );

    // Readiness depends only on occupancy: a full buffer never accepts,
    // even when the head is being popped in the same cycle.
    assign INSTR_READY = (r_count < 2'(DEPTH)) & ~RST;
    assign IMM_VALID   = (r_count != 2'd0);
    assign w_push      = INSTR_VALID & INSTR_READY;
    assign w_pop       = IMM_VALID & IMM_READY;

    // Empty buffer presents an all-zero NONE entry rather than stale data.
    assign w_head    = IMM_VALID ? r_mem[r_rd_ptr] : '0;
    assign IMM_CLASS = w_head.cls;
    assign IMM3      = w_head.imm3;
    assign IMM5      = w_head.imm5;
    assign IMM8      = w_head.imm8;
    assign IMM11     = w_head.imm11;
    assign NONE_CNT  = r_none_cnt;

    // Entry storage needs no reset; validity is tracked by r_count alone.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_dec;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_none_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_dec.cls == CLS_NONE && r_none_cnt != {CNT_W{1'b1}}) begin
                r_none_cnt <= r_none_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imm_field_extract.sv
// tb/tb_imm_field_extract.sv - scoreboard bench for imm_field_extract
module tb_imm_field_extract;
    import imm_pkg::*;

    logic        CLK;
    logic        RST;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [15:0] INSTR;
    logic        IMM_VALID;
    logic        IMM_READY;
    logic [2:0]  IMM_CLASS;
    logic [2:0]  IMM3;
    logic [4:0]  IMM5;
    logic [7:0]  IMM8;
    logic [10:0] IMM11;
    logic [7:0]  NONE_CNT;

    int tests = 0;
    int fails = 0;

    imm_entry_t exp_q[$];
    imm_entry_t obs_q[$];

    imm_field_extract #(.CNT_W(8)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY),
        .INSTR       (INSTR),
        .IMM_VALID   (IMM_VALID),
        .IMM_READY   (IMM_READY),
        .IMM_CLASS   (IMM_CLASS),
        .IMM3        (IMM3),
        .IMM5        (IMM5),
        .IMM8        (IMM8),
        .IMM11       (IMM11),
        .NONE_CNT    (NONE_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic imm_entry_t ref_decode(input logic [15:0] w);
        imm_entry_t r;
        r = '0;
        casez (w[15:9])
            7'b000111?: begin r.cls = CLS_IMM3; r.imm3 = w[8:6]; end
            7'b00000??, 7'b00001??, 7'b00010??,
            7'b011????, 7'b1000???: begin r.cls = CLS_IMM5; r.imm5 = w[10:6]; end
            7'b001????, 7'b01001??, 7'b1001???,
            7'b1010???: begin r.cls = CLS_IMM8; r.imm8 = w[7:0]; end
            7'b1101111: r = '0;
            7'b1101???: begin r.cls = CLS_IMM8; r.imm8 = w[7:0]; end
            7'b11100??: begin r.cls = CLS_IMM11; r.imm11 = w[10:0]; end
            default:    r = '0;
        endcase
        return r;
    endfunction

    function automatic imm_entry_t cur_out();
        imm_entry_t r;
        r.cls   = imm_cls_e'(IMM_CLASS);
        r.imm3  = IMM3;
        r.imm5  = IMM5;
        r.imm8  = IMM8;
        r.imm11 = IMM11;
        return r;
    endfunction

    // One clock: sample handshakes mid-cycle, log accepts/pops, move to next negedge.
    task automatic step(output bit acc);
        #1;
        acc = INSTR_VALID && INSTR_READY;
        if (acc) exp_q.push_back(ref_decode(INSTR));
        if (IMM_VALID && IMM_READY) obs_q.push_back(cur_out());
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1; INSTR_VALID = 1'b0; IMM_READY = 1'b0; INSTR = '0;
        repeat (2) @(negedge CLK);
        #1;
        tests++;
        if ({IMM_VALID, INSTR_READY, NONE_CNT, IMM_CLASS} !== 13'd0) begin
            fails++;
            $display("FAIL reset_state: valid=%b ready=%b cnt=%0d cls=%0d, expected all 0",
                     IMM_VALID, INSTR_READY, NONE_CNT, IMM_CLASS);
        end
        tests++;
        if ({IMM3, IMM5, IMM8, IMM11} !== 27'd0) begin
            fails++;
            $display("FAIL reset_fields: got %h expected 0", {IMM3, IMM5, IMM8, IMM11});
        end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        tests++;
        if (INSTR_READY !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset: got %b expected 1", INSTR_READY);
        end
        @(negedge CLK);
    endtask

    task automatic test_imm3();
        bit acc;
        IMM_READY = 1'b1; INSTR = 16'h1D4A; INSTR_VALID = 1'b1;
        step(acc);
        INSTR_VALID = 1'b0;
        #1;
        tests++;
        if (!(acc && IMM_VALID === 1'b1 && IMM_CLASS === 3'd1 && IMM3 === 3'b101 &&
              IMM5 === 5'd0 && IMM8 === 8'd0 && IMM11 === 11'd0)) begin
            fails++;
            $display("FAIL imm3: acc=%b valid=%b cls=%0d f=%h, expected 1 1 1 %h",
                     acc, IMM_VALID, IMM_CLASS, {IMM3, IMM5, IMM8, IMM11}, {3'b101, 24'd0});
        end
        repeat (2) step(acc);
        tests++;
        if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            fails++;
            $display("FAIL imm3_sb: obs=%0d exp=%0d entries, expected 1 matching", obs_q.size(), exp_q.size());
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        bit acc;
        logic [15:0] words [3] = '{16'h0D40, 16'h20AA, 16'hE555};
        imm_entry_t  spec  [3];
        imm_entry_t  o, e;
        int          vcyc = 0;
        spec[0] = '{cls: CLS_IMM5,  imm3: 3'd0, imm5: 5'b10101, imm8: 8'd0,  imm11: 11'd0};
        spec[1] = '{cls: CLS_IMM8,  imm3: 3'd0, imm5: 5'd0,     imm8: 8'hAA, imm11: 11'd0};
        spec[2] = '{cls: CLS_IMM11, imm3: 3'd0, imm5: 5'd0,     imm8: 8'd0,  imm11: 11'b10101010101};
        IMM_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            INSTR = words[i]; INSTR_VALID = 1'b1;
            if (IMM_VALID) vcyc++;
            step(acc);
        end
        INSTR_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (IMM_VALID) vcyc++;
            step(acc);
        end
        tests++;
        if (vcyc != 3) begin
            fails++;
            $display("FAIL b2b_valid_cycles: got %0d expected 3", vcyc);
        end
        for (int i = 0; i < 3; i++) begin
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            tests++;
            if (o !== spec[i] || e !== spec[i]) begin
                fails++;
                $display("FAIL b2b_entry%0d: got %h model %h expected %h", i, o, e, spec[i]);
            end
        end
        tests++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_extra: obs=%0d exp=%0d expected 0 0", obs_q.size(), exp_q.size());
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        bit acc;
        int n_acc = 0;
        int guard = 0;
        imm_entry_t first, o, e;
        logic [15:0] words [3] = '{16'h4812, 16'h6A80, 16'hE001};
        IMM_READY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            INSTR = words[i]; INSTR_VALID = 1'b1;
            step(acc);
            if (acc) n_acc++;
        end
        INSTR = words[2];
        #1;
        first = cur_out();
        tests++;
        if (n_acc != 2 || INSTR_READY !== 1'b0 || IMM_VALID !== 1'b1) begin
            fails++;
            $display("FAIL bp_full: acc=%0d ready=%b valid=%b, expected 2 0 1", n_acc, INSTR_READY, IMM_VALID);
        end
        step(acc);
        tests++;
        if (acc || cur_out() !== first || first !== ref_decode(words[0])) begin
            fails++;
            $display("FAIL bp_hold: acc=%b head=%h, expected 0 %h", acc, cur_out(), ref_decode(words[0]));
        end
        IMM_READY = 1'b1;
        step(acc);
        tests++;
        if (acc) begin
            fails++;
            $display("FAIL bp_no_passthru: acc=%b expected 0", acc);
        end
        while (!acc && guard < 10) begin
            step(acc);
            guard++;
        end
        INSTR_VALID = 1'b0;
        tests++;
        if (!acc) begin
            fails++;
            $display("FAIL bp_third_accept: got 0 expected 1");
        end
        repeat (4) step(acc);
        tests++;
        if (obs_q.size() != 3 || exp_q.size() != 3) begin
            fails++;
            $display("FAIL bp_count: obs=%0d exp=%0d expected 3 3", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL bp_entry%0d: got %h expected %h", i, o, e);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_unclassified();
        bit acc;
        int n_acc = 0;
        int guard = 0;
        int bad = 0;
        imm_entry_t o, e;
        IMM_READY = 1'b1; INSTR = 16'hDF00; INSTR_VALID = 1'b1;
        step(acc);
        INSTR_VALID = 1'b0;
        #1;
        tests++;
        if (!(acc && IMM_VALID === 1'b1 && cur_out() === imm_entry_t'(0) && NONE_CNT === 8'd1)) begin
            fails++;
            $display("FAIL none_single: acc=%b valid=%b out=%h cnt=%0d, expected 1 1 0 1",
                     acc, IMM_VALID, cur_out(), NONE_CNT);
        end
        step(acc);
        INSTR_VALID = 1'b1;
        while (n_acc < 300 && guard < 1000) begin
            INSTR = (n_acc % 2) ? 16'hDE00 : 16'hDF00;
            if (n_acc == 254) INSTR = 16'hB000;
            step(acc);
            if (acc) n_acc++;
            guard++;
        end
        INSTR_VALID = 1'b0;
        repeat (3) step(acc);
        tests++;
        if (NONE_CNT !== 8'd255) begin
            fails++;
            $display("FAIL none_saturate: got %0d expected 255", NONE_CNT);
        end
        tests++;
        if (obs_q.size() != 301 || exp_q.size() != 301) begin
            fails++;
            $display("FAIL none_count: obs=%0d exp=%0d expected 301 301", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (o !== e) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL none_entries: got %0d mismatching entries expected 0", bad);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        bit acc;
        imm_entry_t want;
        want = '{cls: CLS_IMM8, imm3: 3'd0, imm5: 5'd0, imm8: 8'hAA, imm11: 11'd0};
        IMM_READY = 1'b0; INSTR_VALID = 1'b1;
        INSTR = 16'h0D40; step(acc);
        INSTR = 16'hDF00; step(acc);
        INSTR_VALID = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        #1;
        tests++;
        if (IMM_VALID !== 1'b0 || NONE_CNT !== 8'd0 || INSTR_READY !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: valid=%b cnt=%0d ready=%b, expected 0 0 0", IMM_VALID, NONE_CNT, INSTR_READY);
        end
        exp_q.delete(); obs_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        IMM_READY = 1'b1; INSTR = 16'h20AA; INSTR_VALID = 1'b1;
        step(acc);
        INSTR_VALID = 1'b0;
        repeat (4) step(acc);
        tests++;
        if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== want || exp_q[0] !== want) begin
            fails++;
            $display("FAIL mid_reset_fresh: obs=%0d entries first=%h, expected 1 entry %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : imm_entry_t'(0), want);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_imm3();
        test_back_to_back();
        test_backpressure();
        test_unclassified();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
